// File: rtl/vga_timing_checker.sv
// VGA timing checker: measures line/frame geometry of an incoming VGA sync
// stream, acquires lock after clean frames and flags timing errors.
//
// Ports:
//   clk25        pixel clock (rising edge)
//   reset_n      asynchronous active-low reset
//   hsync/vsync  sync inputs, active level SYNC_POL
//   blank        high = blanking, low = active pixel
//   clear_err    pulse: clears h_err, v_err, err_count
//   pix_x/pix_y  active pixel / active line index
//   pix_valid    active pixel while locked
//   frame_start  one-cycle pulse per vsync leading edge
//   locked       checker in LOCKED state
//   line_len     last measured line period (clocks)
//   frame_lines  last measured frame length (lines)
//   h_err/v_err  sticky timing error flags
//   err_count    saturating count of lock losses
module vga_timing_checker #(
   parameter int H_ACTIVE    = 640,
   parameter int H_TOTAL     = 800,
   parameter int V_ACTIVE    = 480,
   parameter int V_TOTAL     = 525,
   parameter bit SYNC_POL    = 1'b0,
   parameter int LOCK_FRAMES = 2
) (
   input  logic       clk25,
   input  logic       reset_n,
   input  logic       hsync,
   input  logic       vsync,
   input  logic       blank,
   input  logic       clear_err,
   output logic [9:0] pix_x,
   output logic [9:0] pix_y,
   output logic       pix_valid,
   output logic       frame_start,
   output logic       locked,
   output logic [9:0] line_len,
   output logic [9:0] frame_lines,
   output logic       h_err,
   output logic       v_err,
   output logic [7:0] err_count
);

   localparam logic [1:0] S_SEARCH = 2'd0;
   localparam logic [1:0] S_ALIGN  = 2'd1;
   localparam logic [1:0] S_LOCKED = 2'd2;

   localparam logic [9:0]  HT    = 10'(H_TOTAL);
   localparam logic [9:0]  VT    = 10'(V_TOTAL);
   localparam logic [10:0] HA_W  = 11'(H_ACTIVE);
   localparam logic [10:0] VA_W  = 11'(V_ACTIVE);
   localparam logic [7:0]  LCK_N = 8'(LOCK_FRAMES);
   localparam logic [9:0]  SAT10 = 10'h3FF;
   localparam logic [7:0]  SAT8  = 8'hFF;

   logic       hs_q, vs_q, bl_q;
   logic [9:0] cyc_q, cyc_d;
   logic [9:0] ln_q, ln_d;
   logic [9:0] px_q, px_d;
   logic [9:0] py_q, py_d;
   logic [9:0] ll_q, ll_d;
   logic [9:0] fl_q, fl_d;
   logic [1:0] state_q, state_d;
   logic [7:0] good_q, good_d;
   logic       fbad_q, fbad_d;
   logic       lseen_q, lseen_d;
   logic       fs_q, fs_d;
   logic       herr_q, herr_d;
   logic       verr_q, verr_d;
   logic [7:0] errc_q, errc_d;

   logic        hs_le, vs_le, checking;
   logic [10:0] act_cnt, len_meas, ln_end, ay_end;
   logic        line_act;
   logic [9:0]  ll_new, fl_new;
   logic        h_bad, v_bad, drop;

   // Edges compare the fresh sample against the registered previous
   // sample, so every registered output lags its cause by one cycle.
   assign hs_le = (hsync == SYNC_POL) && (hs_q != SYNC_POL);
   assign vs_le = (vsync == SYNC_POL) && (vs_q != SYNC_POL);
   assign checking = (state_q != S_SEARCH);

   // The previous sample (bl_q) still belongs to the ending line.
   assign act_cnt  = {1'b0, px_q} + {10'd0, ~bl_q};
   assign line_act = (act_cnt != 11'd0);

   assign len_meas = {1'b0, cyc_q} + 11'd1;
   assign ll_new   = len_meas[10] ? SAT10 : len_meas[9:0];

   // Line handling precedes frame handling: a coincident hsync edge
   // closes its line into the ending frame.
   assign ln_end = {1'b0, ln_q} + {10'd0, hs_le};
   assign fl_new = ln_end[10] ? SAT10 : ln_end[9:0];
   assign ay_end = {1'b0, py_q} + {10'd0, hs_le & line_act};

   // lseen_q masks the partial line that follows reset.
   assign h_bad = hs_le && checking && lseen_q &&
                  ((ll_new != HT) ||
                   (line_act && (act_cnt != HA_W)));
   assign v_bad = vs_le && checking &&
                  ((fl_new != VT) || (ay_end != VA_W));

   always_comb begin
      cyc_d = hs_le ? 10'd0 :
              (cyc_q == SAT10) ? cyc_q : cyc_q + 10'd1;
      ll_d  = hs_le ? ll_new : ll_q;
      ln_d  = ln_q;
      if (vs_le)
         ln_d = 10'd0;
      else if (hs_le && ln_q != SAT10)
         ln_d = ln_q + 10'd1;
      fl_d  = vs_le ? fl_new : fl_q;
      px_d  = px_q;
      if (hs_le)
         px_d = 10'd0;
      else if (!bl_q && px_q != SAT10)
         px_d = px_q + 10'd1;
      py_d  = py_q;
      if (vs_le)
         py_d = 10'd0;
      else if (hs_le && line_act && py_q != SAT10)
         py_d = py_q + 10'd1;
      fs_d    = vs_le;
      lseen_d = lseen_q | hs_le;
   end

   always_comb begin
      state_d = state_q;
      good_d  = good_q;
      fbad_d  = fbad_q;
      drop    = 1'b0;
      unique case (state_q)
         S_SEARCH: begin
            if (vs_le) begin
               state_d = S_ALIGN;
               good_d  = 8'd0;
               fbad_d  = 1'b0;
            end
         end
         S_ALIGN: begin
            if (h_bad)
               fbad_d = 1'b1;
            if (vs_le) begin
               fbad_d = 1'b0;
               if (fbad_q || h_bad || v_bad)
                  good_d = 8'd0;
               else if (good_q + 8'd1 >= LCK_N) begin
                  state_d = S_LOCKED;
                  good_d  = 8'd0;
               end else
                  good_d = good_q + 8'd1;
            end
         end
         S_LOCKED: begin
            if (h_bad || v_bad) begin
               state_d = S_SEARCH;
               drop    = 1'b1;
            end
         end
         default: state_d = S_SEARCH;
      endcase
   end

   // A new error outranks a coincident clear.
   always_comb begin
      herr_d = (clear_err ? 1'b0 : herr_q) | h_bad;
      verr_d = (clear_err ? 1'b0 : verr_q) | v_bad;
      errc_d = clear_err ? 8'd0 : errc_q;
      if (drop && errc_d != SAT8)
         errc_d = errc_d + 8'd1;
   end

   always_ff @(posedge clk25 or negedge reset_n) begin
      if (!reset_n) begin
         hs_q    <= ~SYNC_POL;
         vs_q    <= ~SYNC_POL;
         bl_q    <= 1'b1;
         cyc_q   <= 10'd0;
         ln_q    <= 10'd0;
         px_q    <= 10'd0;
         py_q    <= 10'd0;
         ll_q    <= 10'd0;
         fl_q    <= 10'd0;
         state_q <= S_SEARCH;
         good_q  <= 8'd0;
         fbad_q  <= 1'b0;
         lseen_q <= 1'b0;
         fs_q    <= 1'b0;
         herr_q  <= 1'b0;
         verr_q  <= 1'b0;
         errc_q  <= 8'd0;
      end else begin
         hs_q    <= hsync;
         vs_q    <= vsync;
         bl_q    <= blank;
         cyc_q   <= cyc_d;
         ln_q    <= ln_d;
         px_q    <= px_d;
         py_q    <= py_d;
         ll_q    <= ll_d;
         fl_q    <= fl_d;
         state_q <= state_d;
         good_q  <= good_d;
         fbad_q  <= fbad_d;
         lseen_q <= lseen_d;
         fs_q    <= fs_d;
         herr_q  <= herr_d;
         verr_q  <= verr_d;
         errc_q  <= errc_d;
      end
   end

   assign pix_x       = px_q;
   assign pix_y       = py_q;
   assign locked      = (state_q == S_LOCKED);
   assign pix_valid   = ~bl_q & locked;
   assign frame_start = fs_q;
   assign line_len    = ll_q;
   assign frame_lines = fl_q;
   assign h_err       = herr_q;
   assign v_err       = verr_q;
   assign err_count   = errc_q;

endmodule

// File: tb/tb_vga_timing_checker.sv
// Directed bench for vga_timing_checker on a reduced 16x6 (20x8) raster.
// Lines start with hsync low for 2 clocks; vsync is low for all of line 0.
module tb_vga_timing_checker;

   localparam int HA = 16;
   localparam int HT = 20;
   localparam int VA = 6;
   localparam int VT = 8;

   logic       clk25 = 1'b0;
   logic       reset_n, hsync, vsync, blank, clear_err;
   logic [9:0] pix_x, pix_y, line_len, frame_lines;
   logic       pix_valid, frame_start, locked, h_err, v_err;
   logic [7:0] err_count;

   int n_vec  = 0;
   int n_miss = 0;

   logic       e_fs, e_lock, e_verr;
   logic [9:0] e_fl;
   logic [7:0] e_ec;
   logic       s_fs, s_lock, s_herr;
   logic [9:0] s_ll;
   logic [7:0] s_ec;
   int px_bad, pv_cnt, max_x, max_y;
   int clr_l = -1;
   int clr_c = -1;

   vga_timing_checker #(
      .H_ACTIVE(HA), .H_TOTAL(HT),
      .V_ACTIVE(VA), .V_TOTAL(VT),
      .SYNC_POL(1'b0), .LOCK_FRAMES(2)
   ) dut (
      .clk25(clk25), .reset_n(reset_n),
      .hsync(hsync), .vsync(vsync),
      .blank(blank), .clear_err(clear_err),
      .pix_x(pix_x), .pix_y(pix_y),
      .pix_valid(pix_valid),
      .frame_start(frame_start),
      .locked(locked), .line_len(line_len),
      .frame_lines(frame_lines),
      .h_err(h_err), .v_err(v_err),
      .err_count(err_count)
   );

   always #5 clk25 = ~clk25;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0d expected %0d",
                  tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk25);
      #1;
   endtask

   task automatic idle();
      hsync = 1'b1;
      vsync = 1'b1;
      blank = 1'b1;
      clear_err = 1'b0;
   endtask

   task automatic drive_line(input int l, input int len);
      for (int c = 0; c < len; c++) begin
         hsync = (c < 2) ? 1'b0 : 1'b1;
         vsync = (l == 0) ? 1'b0 : 1'b1;
         blank = !((l >= 1) && (l <= VA) &&
                   (c >= 2) && (c < 2 + HA));
         clear_err = (l == clr_l) && (c == clr_c);
         tick();
         if (c == 0) begin
            s_fs   = frame_start;
            s_lock = locked;
            s_herr = h_err;
            s_ll   = line_len;
            s_ec   = err_count;
            if (l == 0) begin
               e_fs   = frame_start;
               e_lock = locked;
               e_verr = v_err;
               e_fl   = frame_lines;
               e_ec   = err_count;
            end
         end
         if (pix_valid) begin
            pv_cnt++;
            if (pix_x != 10'(c - 2) || pix_y != 10'(l - 1))
               px_bad++;
            if (int'(pix_x) > max_x) max_x = int'(pix_x);
            if (int'(pix_y) > max_y) max_y = int'(pix_y);
         end
      end
      clear_err = 1'b0;
   endtask

   task automatic run_lines(input int from, input int to,
                            input int bad, input int blen);
      for (int l = from; l <= to; l++)
         drive_line(l, (l == bad) ? blen : HT);
   endtask

   function automatic logic any_out();
      return |{pix_x, pix_y, pix_valid, frame_start,
               locked, line_len, frame_lines,
               h_err, v_err, err_count};
   endfunction

   initial begin
      reset_n = 1'b0;
      idle();
      #12;
      chk("rst_outs", 32'(any_out()), 0);
      @(negedge clk25);
      reset_n = 1'b1;

      // partial line and partial frame while searching
      repeat (9) tick();
      run_lines(6, 7, -1, 0);

      run_lines(0, VT - 1, -1, 0);
      chk("fs_edge1", 32'(e_fs), 1);
      chk("lock_e1", 32'(e_lock), 0);
      run_lines(0, VT - 1, -1, 0);
      chk("lock_e2", 32'(e_lock), 0);
      chk("fl_align", 32'(e_fl), VT);

      px_bad = 0; pv_cnt = 0; max_x = 0; max_y = 0;
      run_lines(0, VT - 1, -1, 0);
      chk("lock_e3", 32'(e_lock), 1);
      chk("fl_coinc", 32'(e_fl), VT);
      chk("verr_coinc", 32'(e_verr), 0);
      chk("pv_cnt", 32'(pv_cnt), HA * VA);
      chk("px_seq", 32'(px_bad), 0);
      chk("max_x", 32'(max_x), HA - 1);
      chk("max_y", 32'(max_y), VA - 1);
      chk("line_len", 32'(line_len), HT);
      chk("herr_nom", 32'(h_err), 0);

      // one long line while locked
      run_lines(0, 4, 3, HT + 1);
      chk("ll_long", 32'(s_ll), HT + 1);
      chk("herr_long", 32'(s_herr), 1);
      chk("lock_drop", 32'(s_lock), 0);
      chk("ec_drop", 32'(s_ec), 1);
      chk("fs_mid", 32'(s_fs), 0);
      run_lines(5, VT - 1, -1, 0);

      run_lines(0, VT - 1, -1, 0);
      run_lines(0, VT - 1, -1, 0);
      chk("relock_e2", 32'(e_lock), 0);
      chk("ec_hold", 32'(e_ec), 1);
      clr_l = 2; clr_c = 5;
      run_lines(0, VT - 1, -1, 0);
      clr_l = -1;
      chk("relock_e3", 32'(e_lock), 1);
      chk("herr_clr", 32'(h_err), 0);
      chk("ec_clr", 32'(err_count), 0);

      // one frame with an extra line
      run_lines(0, VT, -1, 0);
      clr_l = 3; clr_c = 7;
      run_lines(0, VT - 1, -1, 0);
      clr_l = -1;
      chk("fl_long", 32'(e_fl), VT + 1);
      chk("verr_long", 32'(e_verr), 1);
      chk("lock_vdrop", 32'(e_lock), 0);
      chk("ec_vdrop", 32'(e_ec), 1);
      chk("verr_clr", 32'(v_err), 0);

      // error and clear in the same cycle
      run_lines(0, VT - 1, -1, 0);
      run_lines(0, VT - 1, -1, 0);
      clr_l = 4; clr_c = 0;
      run_lines(0, 4, 3, HT + 1);
      clr_l = -1;
      chk("relock_v", 32'(e_lock), 1);
      chk("herr_prio", 32'(s_herr), 1);
      chk("ec_prio", 32'(s_ec), 1);
      run_lines(5, VT - 1, -1, 0);

      // reset in the middle of a line
      run_lines(0, 2, -1, 0);
      drive_line(3, 9);
      #2;
      reset_n = 1'b0;
      #1;
      chk("rst_mid", 32'(any_out()), 0);
      idle();
      repeat (3) tick();
      @(negedge clk25);
      reset_n = 1'b1;
      run_lines(0, VT - 1, -1, 0);
      chk("rl_e1", 32'(e_lock), 0);
      run_lines(0, VT - 1, -1, 0);
      chk("rl_e2", 32'(e_lock), 0);
      run_lines(0, VT - 1, -1, 0);
      chk("rl_e3", 32'(e_lock), 1);
      chk("ec_rst", 32'(e_ec), 0);

      // line period beyond the counter range
      run_lines(0, 2, 1, 1100);
      chk("ll_sat", 32'(s_ll), 1023);
      chk("herr_sat", 32'(s_herr), 1);

      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/vga_timing_checker.md
VGA_TIMING_CHECKER -- requirements
Module: vga_timing_checker

Interface
REQ-001 H_ACTIVE, 640, active pixels per line.
REQ-002 H_TOTAL, 800, clocks per line (hsync leading edge to next leading edge).
REQ-003 V_ACTIVE, 480, active lines per frame.
REQ-004 V_TOTAL, 525, lines per frame (vsync leading edge to next leading edge).
REQ-005 SYNC_POL, 0, active level of hsync and vsync (0 = active-low).
REQ-006 LOCK_FRAMES, 2, consecutive error-free frames required to reach LOCKED.
REQ-007 clk25 input 1 pixel clock; all logic SHALL be on its rising edge.
REQ-008 reset_n input 1 asynchronous active-low reset.
REQ-009 hsync input 1 horizontal sync from the VGA timing generator.
REQ-010 vsync input 1 vertical sync.
REQ-011 blank input 1 high = blanking interval, low = active pixel.
REQ-012 clear_err input 1 one-cycle pulse that clears the error state.
REQ-013 pix_x output 10 index of the current active pixel within its line.
REQ-014 pix_y output 10 index of the current active line within its frame.
REQ-015 pix_valid output 1 current pixel is active and the checker is LOCKED.
REQ-016 frame_start output 1 one-cycle pulse on each vsync leading edge.
REQ-017 locked output 1 high in state LOCKED.
REQ-018 line_len output 10 last measured line period in clocks.
REQ-019 frame_lines output 10 last measured frame length in lines.
REQ-020 h_err, v_err output 1 each sticky horizontal / vertical timing error flags.
REQ-021 err_count output 8 count of LOCKED-to-SEARCH drops, saturating.

Function
REQ-022 hsync, vsync and blank SHALL be registered once; edges SHALL be detected on the registered copies; every output SHALL lag its causing input sample by exactly 1 cycle.
REQ-023 Leading edge = transition into the SYNC_POL level.
REQ-024 Cycle counter: clears at each hsync leading edge; line_len latches the clock count since the previous leading edge; saturates at 1023.
REQ-025 Line counter: advances at each hsync leading edge; at each vsync leading edge, frame_lines latches the line count and the counter restarts; saturates at 1023.
REQ-026 pix_x: clears at each hsync leading edge; increments after each active cycle; saturates at 1023.
REQ-027 pix_y: clears at each vsync leading edge; increments at an hsync leading edge only if the ending line contained active cycles.
REQ-028 pix_valid = registered (~blank) AND locked.
REQ-029 Horizontal error: in ALIGN or LOCKED, at an hsync leading edge, line_len != H_TOTAL, or the ending line had active cycles with count != H_ACTIVE.
REQ-030 Vertical error: at a vsync leading edge in ALIGN or LOCKED, frame_lines != V_TOTAL or active-line count != V_ACTIVE.
REQ-031 FSM SEARCH: move to ALIGN on the first vsync leading edge; the error checks of REQ-029 and REQ-030 are disabled in this state.
REQ-032 FSM ALIGN: a frame-checking error resets the good-frame count to 0; an error-free frame increments it; move to LOCKED when it reaches LOCK_FRAMES.
REQ-033 FSM LOCKED: any error returns to SEARCH and increments err_count (saturates at 255).
REQ-034 Errors SHALL set h_err / v_err, which remain high until clear_err.
REQ-035 clear_err SHALL zero h_err, v_err and err_count; a coincident new error takes priority and is recorded.
REQ-036 Simultaneous hsync and vsync leading edges: line handling SHALL complete first, so the ending line is counted in frame_lines and in the active-line total.
REQ-037 The first partial line and first partial frame after SEARCH SHALL NOT be checked.

Reset
REQ-038 On reset_n low: FSM = SEARCH, all counters 0, all outputs 0, input registers at the inactive sync level with blank = 1.
REQ-039 reset_n SHALL be asserted asynchronously and released synchronously to clk25; reset mid-frame restarts acquisition from SEARCH.

Verification
REQ-040 Nominal 640x480 stimulus (800x525): locked rises at the 3rd vsync edge; line_len=800; frame_lines=525; pix_x runs 0..639; pix_y runs 0..479.
REQ-041 One 801-clock line while LOCKED: h_err=1, locked=0, err_count=1; relock after 2 good frames.
REQ-042 Frame with 526 lines: v_err=1, frame_lines=526.
REQ-043 Coincident hsync and vsync edges: frame_lines=525, no v_err.
REQ-044 clear_err in the same cycle as an error: h_err stays 1; err_count increments.
REQ-045 reset_n low mid-line: all outputs 0 immediately; locked rises again after 3 vsync edges.
